ntt_butterfly_pe: RTL and testbench
===================================

NTT_BUTTERFLY_PE -- requirements
Module: ntt_pe

Interface
REQ-001 The module SHALL have parameter N, default 17, giving the width in bits of each coefficient word.
REQ-002 The module SHALL have parameter Q, default 65537, giving the prime modulus; the requirements below are written for 2^(N-1) < Q < 2^N.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: a, b, c and sub carry a valid operation this cycle.
REQ-006 Port a, input, N bits: butterfly upper operand.
REQ-007 Port b, input, N bits: butterfly lower operand.
REQ-008 Port c, input, N bits: twiddle factor (psi power).
REQ-009 Port sub, input, 1 bit: 0 selects a + b*c; 1 selects a - b*c.
REQ-010 Port out_valid, output, 1 bit: s holds a valid result this cycle.
REQ-011 Port s, output, N bits: butterfly result, always in the range 0..Q-1.

Function
REQ-012 The result SHALL be s = (a + b*c) mod Q when sub=0, and s = (a - b*c) mod Q when sub=1, using mathematical (non-negative) modulo.
REQ-013 Any input a, b or c with a value >= Q SHALL be treated as (value mod Q) before use; no error SHALL be flagged.
REQ-014 The product b*c SHALL be computed at full 2N-bit width and reduced mod Q, with no truncation before reduction.
REQ-015 Addition and subtraction SHALL use a single conditional correction: a+p >= Q subtracts Q; a-p < 0 adds Q.
REQ-016 The output SHALL never equal Q; a result of exactly Q SHALL appear as 0.
REQ-017 The datapath SHALL be fully pipelined: one operation accepted per cycle, no stall, and no backpressure input.
REQ-018 The baseline latency SHALL be 2 cycles. Stage 1 registers (a mod Q), (b*c mod Q) and sub. Stage 2 registers s.
REQ-019 out_valid SHALL equal in_valid delayed by exactly the pipeline latency.
REQ-020 s and out_valid SHALL update together, in the same cycle.
REQ-021 When in_valid=0, the data registers in that stage SHALL still update; s content is don't-care while out_valid=0.
REQ-022 Back-to-back operations SHALL produce back-to-back results in issue order.
REQ-023 The sub bit SHALL travel through the pipeline with its own operation.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately clear all pipeline valid bits, out_valid and s to 0, regardless of clk.
REQ-025 Operations in flight when reset asserts SHALL be discarded; no partial result SHALL emerge after reset.
REQ-026 After rst_n deasserts, the first in_valid SHALL produce out_valid exactly one latency later.

Configuration
REQ-027 Macro NTT_PE_PIPE_EN, when defined, SHALL add a register between the raw 2N-bit product and the mod-Q reduction, making the latency 3 cycles. out_valid SHALL track the new latency, and the function SHALL be unchanged.
REQ-028 When NTT_PE_PIPE_EN is undefined, multiplication and reduction SHALL occur in one stage, for a latency of 2 cycles.

Verification
REQ-029 Basic add/sub: a=5, b=3, c=4 with sub=0 -> s=17; with sub=1 -> s=65530; each appears after the configured latency.
REQ-030 Wrap to zero: a=65536, b=65536, c=65536, sub=0 -> s=0; same operands with sub=1 -> s=65535.
REQ-031 Product reduction: a=1, b=256, c=256, sub=0 -> s=0; a=0, b=0, c=12345, sub=1 -> s=0, not Q.
REQ-032 Out-of-range input: a=65537, b=1, c=1, sub=0 -> s=1; a=131071, b=0, c=0, sub=0 -> s=65534.
REQ-033 Throughput: 8 consecutive valid operations, random inputs < Q -> 8 consecutive out_valid cycles with results matching a software model, in order.
REQ-034 Reset mid-stream: assert rst_n=0 asynchronously while 2 operations are in flight -> out_valid=0 and s=0 at once, and no stale out_valid after release.

Source files
------------

// File: rtl/ntt_butterfly_pe.sv
`default_nettype none
// ============================================================================
// Module   : ntt_butterfly_pe
// Desc     : Pipelined NTT butterfly element, s = (a +/- b*c) mod Q.
//            Operands at or above Q are folded into 0..Q-1 before use and the
//            result is always in 0..Q-1. One operation per cycle, no stall.
// Config   : NTT_PE_PIPE_EN - when defined, registers the raw 2N-bit product
//            ahead of the mod-Q reduction (latency 3 instead of 2).
// Revision : 1.0 - initial release
// ============================================================================
module ntt_butterfly_pe #(
    parameter int N = 17,
    parameter int Q = 65537
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic         sub,
    output logic         out_valid,
    output logic [N-1:0] s
);

    // Modulus at the widths each arithmetic step needs
    localparam logic [N-1:0]   c_q    = N'(Q);
    localparam logic [N:0]     c_q_n1 = (N+1)'(Q);
    localparam logic [2*N-1:0] c_q_2n = (2*N)'(Q);

    // Full-width product: nothing is truncated before the reduction
    logic [2*N-1:0] w_prod;
    assign w_prod = {{N{1'b0}}, b} * {{N{1'b0}}, c};

    // Operands feeding the reduction stage (direct, or via the product register)
    logic [2*N-1:0] w_prod_src;
    logic [N-1:0]   w_a_src;
    logic           w_sub_src;
    logic           w_v_src;

`ifdef NTT_PE_PIPE_EN
    logic [2*N-1:0] r_prod0;
    logic [N-1:0]   r_a0;
    logic           r_sub0;
    logic           r_v0;

    // Product register: breaks the multiplier away from the modulo reduction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0    <= 1'b0;
            r_prod0 <= '0;
            r_a0    <= '0;
            r_sub0  <= 1'b0;
        end else begin
            r_v0    <= in_valid;
            r_prod0 <= w_prod;
            r_a0    <= a;
            r_sub0  <= sub;
        end
    end

    assign w_prod_src = r_prod0;
    assign w_a_src    = r_a0;
    assign w_sub_src  = r_sub0;
    assign w_v_src    = r_v0;
`else
    assign w_prod_src = w_prod;
    assign w_a_src    = a;
    assign w_sub_src  = sub;
    assign w_v_src    = in_valid;
`endif

    // a < 2^N < 2Q, so one conditional subtract folds it into 0..Q-1
    logic [N-1:0] w_a_red;
    logic [N-1:0] w_p_red;
    assign w_a_red = (w_a_src >= c_q) ? (w_a_src - c_q) : w_a_src;
    assign w_p_red = N'(w_prod_src % c_q_2n);

    logic [N-1:0] r_a1;
    logic [N-1:0] r_p1;
    logic         r_sub1;
    logic         r_v1;

    // Stage 1: reduced operand, reduced product, and the op's own sub bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_a1   <= '0;
            r_p1   <= '0;
            r_sub1 <= 1'b0;
        end else begin
            r_v1   <= w_v_src;
            r_a1   <= w_a_red;
            r_p1   <= w_p_red;
            r_sub1 <= w_sub_src;
        end
    end

    // Both terms are already < Q, so one correction step lands in 0..Q-1;
    // a sum of exactly Q takes the subtract path and becomes 0.
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic [N-1:0] w_add_res;
    logic [N-1:0] w_sub_res;
    assign w_sum     = {1'b0, r_a1} + {1'b0, r_p1};
    assign w_diff    = {1'b0, r_a1} - {1'b0, r_p1};
    assign w_add_res = (w_sum >= c_q_n1) ? N'(w_sum - c_q_n1) : N'(w_sum);
    assign w_sub_res = (r_a1 < r_p1) ? N'(w_diff + c_q_n1) : N'(w_diff);

    // Stage 2: result and valid leave together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
        end else begin
            out_valid <= r_v1;
            s         <= r_sub1 ? w_sub_res : w_add_res;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_butterfly_pe
// Desc     : Self-checking bench for ntt_butterfly_pe (N=17, Q=65537).
//            Table vectors, random streams against a plain-arithmetic model,
//            and an asynchronous mid-stream reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_butterfly_pe;

    localparam int N = 17;
    localparam int Q = 65537;
`ifdef NTT_PE_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic         sub;
    logic         out_valid;
    logic [N-1:0] s;

    ntt_butterfly_pe #(.N(N), .Q(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .sub       (sub),
        .out_valid (out_valid),
        .s         (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] c;
        logic         sub;
        logic [N-1:0] s;
    } vec_t;

    typedef struct {
        logic         v;
        logic [N-1:0] s;
        int           tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag_n = 0;

    // Reference: plain modular arithmetic on wide integers
    function automatic logic [N-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                           input logic [N-1:0] mc, input logic msub);
        longint am, p, r;
        am = longint'(ma) % Q;
        p  = (longint'(mb) * longint'(mc)) % Q;
        r  = msub ? (am - p) : (am + p);
        r  = ((r % Q) + Q) % Q;
        return N'(r);
    endfunction

    // Compare the outputs with whatever was issued LAT cycles ago
    task automatic check_out();
        exp_t e;
        total++;
        if (q.size() >= LAT) begin
            e = q.pop_front();
            if (out_valid !== e.v || (e.v && s !== e.s)) begin
                bad++;
                $display("FAIL op%0d: got out_valid=%0d s=%0d, required out_valid=%0d s=%0d",
                         e.tag, out_valid, s, e.v, e.s);
            end
        end else if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got out_valid=%0d, required 0", out_valid);
        end
    endtask

    // One cycle: check outputs, then drive the next operation
    task automatic step(input logic v, input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic [N-1:0] ic, input logic isub, input logic [N-1:0] iexp);
        exp_t e;
        @(negedge clk);
        check_out();
        in_valid = v;
        a        = ia;
        b        = ib;
        c        = ic;
        sub      = isub;
        e.v      = v;
        e.s      = iexp;
        e.tag    = tag_n;
        tag_n++;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic rand_op(input logic v, input logic full_range);
        logic [N-1:0] ra, rb, rc;
        logic         rs;
        if (full_range) begin
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = N'($urandom_range(0, (1 << N) - 1));
            rc = N'($urandom_range(0, (1 << N) - 1));
        end else begin
            ra = N'($urandom_range(0, Q - 1));
            rb = N'($urandom_range(0, Q - 1));
            rc = N'($urandom_range(0, Q - 1));
        end
        rs = 1'($urandom_range(0, 1));
        step(v, ra, rb, rc, rs, model(ra, rb, rc, rs));
    endtask

    task automatic check_reset_state(input int tag);
        total++;
        if (out_valid !== 1'b0 || s !== '0) begin
            bad++;
            $display("FAIL reset%0d: got out_valid=%0d s=%0d, required out_valid=0 s=0",
                     tag, out_valid, s);
        end
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{a: 17'd5,      b: 17'd3,      c: 17'd4,      sub: 1'b0, s: 17'd17};
        tbl[1]  = '{a: 17'd5,      b: 17'd3,      c: 17'd4,      sub: 1'b1, s: 17'd65530};
        tbl[2]  = '{a: 17'd65536,  b: 17'd65536,  c: 17'd65536,  sub: 1'b0, s: 17'd0};
        tbl[3]  = '{a: 17'd65536,  b: 17'd65536,  c: 17'd65536,  sub: 1'b1, s: 17'd65535};
        tbl[4]  = '{a: 17'd1,      b: 17'd256,    c: 17'd256,    sub: 1'b0, s: 17'd0};
        tbl[5]  = '{a: 17'd0,      b: 17'd0,      c: 17'd12345,  sub: 1'b1, s: 17'd0};
        tbl[6]  = '{a: 17'd65537,  b: 17'd1,      c: 17'd1,      sub: 1'b0, s: 17'd1};
        tbl[7]  = '{a: 17'd131071, b: 17'd0,      c: 17'd0,      sub: 1'b0, s: 17'd65534};
        tbl[8]  = '{a: 17'd65536,  b: 17'd1,      c: 17'd1,      sub: 1'b0, s: 17'd0};
        tbl[9]  = '{a: 17'd0,      b: 17'd1,      c: 17'd1,      sub: 1'b1, s: 17'd65536};
        tbl[10] = '{a: 17'd131071, b: 17'd131071, c: 17'd131071, sub: 1'b1, s: 17'd65525};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c        = '0;
        sub      = 1'b0;
        #1;
        check_reset_state(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one at a time then back-to-back
        for (int i = 0; i < 11; i++) begin
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sub, tbl[i].s);
            idle(1);
        end
        for (int i = 0; i < 11; i++)
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sub, tbl[i].s);
        idle(LAT);

        // Eight consecutive valid operations, operands below Q
        for (int i = 0; i < 8; i++) rand_op(1'b1, 1'b0);
        idle(LAT);

        // Mixed valid gaps, full-range operands
        for (int i = 0; i < 60; i++) rand_op(1'($urandom_range(0, 1)), 1'b1);
        idle(LAT);

        // Reset asynchronously with two operations in flight
        rand_op(1'b1, 1'b0);
        rand_op(1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_state(1);
        @(negedge clk);
        check_reset_state(2);
        rst_n = 1'b1;
        q.delete();
        idle(LAT + 3);

        // First operation after release appears exactly LAT later
        step(1'b1, 17'd5, 17'd3, 17'd4, 1'b0, 17'd17);
        idle(LAT + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
